// File: rtl/otp_ctrl_zeroize_seq.sv
// Zeroize-and-verify sequencer for one 64-bit OTP block on the native macro port.
// It issues Zeroize, reads the block back, and classifies the set-bit count: pass, retry, fail or fatal.
package otp_ctrl_zeroize_pkg;
    localparam int OtpByteAddrWidth = 11;
    localparam int OtpAddrWidth     = 10;
    localparam int OtpAddrShift     = 1;
    localparam int OtpSizeWidth     = 2;
    localparam int OtpIfWidth       = 64;

    typedef enum logic [3:0] {
        On  = 4'b0101,
        Off = 4'b1010
    } lc_tx_t;

    typedef enum logic [2:0] {
        NoError,
        MacroError,
        MacroEccCorrError,
        MacroEccUncorrError,
        MacroWriteBlankError,
        AccessError,
        CheckFailError,
        FsmStateError
    } otp_err_e;

    // Macro response codes line up with the low end of otp_err_e.
    typedef otp_err_e err_e;

    typedef enum logic [2:0] {
        Read     = 3'd0,
        Write    = 3'd1,
        ReadRaw  = 3'd2,
        WriteRaw = 3'd3,
        Init     = 3'd4,
        Zeroize  = 3'd5
    } cmd_e;
endpackage

module otp_ctrl_zeroize_seq
    import otp_ctrl_zeroize_pkg::*;
#(
    parameter int MaxRetries = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  lc_tx_t                      escalate_en_i,
    input  logic                        zer_req_i,
    input  logic [OtpByteAddrWidth-1:0] zer_addr_i,
    output logic                        zer_ack_o,
    output otp_err_e                    zer_err_o,
    output logic [63:0]                 zer_rdata_o,
    output logic [6:0]                  zer_popcnt_o,
    output logic                        busy_o,
    output logic                        fsm_err_o,
    output logic                        otp_valid_o,
    input  logic                        otp_ready_i,
    output cmd_e                        otp_cmd_o,
    output logic [OtpSizeWidth-1:0]     otp_size_o,
    output logic [OtpAddrWidth-1:0]     otp_addr_o,
    output logic [OtpIfWidth-1:0]       otp_wdata_o,
    input  logic                        otp_rvalid_i,
    input  logic [OtpIfWidth-1:0]       otp_rdata_i,
    input  err_e                        otp_err_i
);

    localparam int          CntW       = $clog2(MaxRetries + 2);
    localparam logic [6:0]  ValidBound = 7'd56;
    localparam logic [6:0]  FatalBound = 7'd48;

    // Sparse encoding leaves unused codes that the default arm traps.
    typedef enum logic [3:0] {
        IDLE     = 4'b0000,
        ZER_CMD  = 4'b0011,
        ZER_WAIT = 4'b0101,
        RD_CMD   = 4'b0110,
        RD_WAIT  = 4'b1001,
        CHECK    = 4'b1010,
        DONE     = 4'b1100,
        ERROR    = 4'b1111
    } state_e;

    state_e                  state_q, state_d;
    logic                    ack_q, ack_d;
    otp_err_e                err_q, err_d;
    logic [OtpAddrWidth-1:0] addr_q, addr_d;
    logic [63:0]             rdata_q, rdata_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [6:0]              popcnt;
    logic                    pending;

    function automatic logic [6:0] popcnt64(input logic [63:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + 7'(d[i]);
        return c;
    endfunction

    assign popcnt = popcnt64(rdata_q);

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        pending = 1'b0;
        case (state_q)
            IDLE: begin
                if (zer_req_i) begin
                    pending = 1'b1;
                    if (zer_addr_i[2:0] != 3'b000) begin
                        state_d = DONE;
                        err_d   = AccessError;
                    end else begin
                        addr_d  = zer_addr_i[OtpByteAddrWidth-1:OtpAddrShift];
                        cnt_d   = '0;
                        state_d = ZER_CMD;
                    end
                end
            end
            ZER_CMD: begin
                pending = 1'b1;
                if (otp_ready_i) state_d = ZER_WAIT;
            end
            ZER_WAIT: begin
                pending = 1'b1;
                if (otp_rvalid_i) begin
                    if (otp_err_i == NoError) begin
                        state_d = RD_CMD;
                    end else begin
                        state_d = DONE;
                        err_d   = otp_err_i;
                    end
                end
            end
            RD_CMD: begin
                pending = 1'b1;
                if (otp_ready_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                pending = 1'b1;
                if (otp_rvalid_i) begin
                    if (otp_err_i == NoError || otp_err_i == MacroEccCorrError) begin
                        rdata_d = otp_rdata_i;
                        state_d = CHECK;
                    end else begin
                        state_d = DONE;
                        err_d   = otp_err_i;
                    end
                end
            end
            CHECK: begin
                pending = 1'b1;
                if (popcnt >= ValidBound) begin
                    state_d = DONE;
                    err_d   = NoError;
                end else if (popcnt >= FatalBound) begin
                    if (cnt_q < CntW'(MaxRetries)) begin
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = ZER_CMD;
                    end else begin
                        state_d = DONE;
                        err_d   = CheckFailError;
                    end
                end else begin
                    state_d = ERROR;
                end
            end
            DONE: state_d = IDLE;
            ERROR: begin
                // A request seen in the ack cycle is the one just answered.
                if (zer_req_i && !ack_q) begin
                    ack_d = 1'b1;
                    err_d = FsmStateError;
                end
            end
            default: state_d = ERROR;
        endcase

        if (otp_rvalid_i && state_q != ZER_WAIT && state_q != RD_WAIT) state_d = ERROR;
        if (escalate_en_i != Off) state_d = ERROR;

        if (state_d == DONE) ack_d = 1'b1;
        if (state_q != ERROR && state_d == ERROR && pending) begin
            ack_d = 1'b1;
            err_d = FsmStateError;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= NoError;
            addr_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign zer_ack_o    = ack_q;
    assign zer_err_o    = err_q;
    assign zer_rdata_o  = rdata_q;
    assign zer_popcnt_o = popcnt;
    assign busy_o       = (state_q != IDLE) && (state_q != ERROR);
    assign fsm_err_o    = (state_q == ERROR);
    assign otp_valid_o  = (state_q == ZER_CMD) || (state_q == RD_CMD);
    assign otp_cmd_o    = (state_q == ZER_CMD) ? Zeroize : Read;
    assign otp_size_o   = OtpSizeWidth'(3);
    assign otp_addr_o   = addr_q;
    assign otp_wdata_o  = '0;

endmodule

// File: tb/tb_otp_ctrl_zeroize_seq.sv
// Directed bench for otp_ctrl_zeroize_seq with a one-cycle-latency macro responder.
module tb_otp_ctrl_zeroize_seq;
    import otp_ctrl_zeroize_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    lc_tx_t      esc = Off;
    logic        req = 1'b0;
    logic [10:0] zaddr = '0;
    logic        ack, busy, fsm_err, otp_valid, otp_ready, otp_rvalid;
    otp_err_e    err;
    logic [63:0] rdata, otp_rdata, otp_wdata;
    logic [6:0]  popcnt;
    cmd_e        otp_cmd;
    logic [1:0]  otp_size;
    logic [9:0]  otp_addr;
    err_e        otp_err;

    always #5 clk = ~clk;

    otp_ctrl_zeroize_seq #(.MaxRetries(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .escalate_en_i(esc),
        .zer_req_i(req), .zer_addr_i(zaddr), .zer_ack_o(ack), .zer_err_o(err),
        .zer_rdata_o(rdata), .zer_popcnt_o(popcnt), .busy_o(busy), .fsm_err_o(fsm_err),
        .otp_valid_o(otp_valid), .otp_ready_i(otp_ready), .otp_cmd_o(otp_cmd),
        .otp_size_o(otp_size), .otp_addr_o(otp_addr), .otp_wdata_o(otp_wdata),
        .otp_rvalid_i(otp_rvalid), .otp_rdata_i(otp_rdata), .otp_err_i(otp_err)
    );

    typedef struct {
        otp_err_e    e;
        logic [63:0] d;
    } rsp_t;

    rsp_t       rsp_q[$];
    cmd_e       log_cmd[$];
    logic [9:0] log_addr[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic       pend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input otp_err_e e, input logic [63:0] d);
        rsp_t r;
        r.e = e;
        r.d = d;
        rsp_q.push_back(r);
    endtask

    // Macro model: answers each accepted command in the following cycle.
    initial begin
        rsp_t r;
        otp_rvalid = 1'b0;
        otp_rdata  = '0;
        otp_err    = NoError;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend       = 1'b0;
                otp_rvalid = 1'b0;
            end else begin
                otp_rvalid = pend;
                if (pend) begin
                    if (rsp_q.size() > 0) r = rsp_q.pop_front();
                    else begin r.e = NoError; r.d = '0; end
                    otp_err   = r.e;
                    otp_rdata = r.d;
                end
                pend = otp_valid && otp_ready;
                if (pend) begin
                    log_cmd.push_back(otp_cmd);
                    log_addr.push_back(otp_addr);
                end
            end
        end
    end

    task automatic run_req(input logic [10:0] a, output int cyc);
        zaddr = a;
        req   = 1'b1;
        cyc   = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (ack) begin cyc = i; break; end
        end
        req = 1'b0;
    endtask

    task automatic ack_gap();
        @(posedge clk); #1;
        chk("ack_pulse", ack, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rsp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  lat;
        logic stable;
        otp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_err", err, NoError);
        chk("rst_busy", busy, 0);
        chk("rst_valid", otp_valid, 0);
        chk("rst_fsm_err", fsm_err, 0);
        chk("rst_size", otp_size, 3);
        chk("rst_rdata", rdata, 0);
        chk("rst_popcnt", popcnt, 0);
        do_reset();

        // All-ones readback on first round.
        log_cmd.delete(); log_addr.delete();
        push(NoError, 64'h0); push(NoError, 64'hFFFF_FFFF_FFFF_FFFF);
        run_req(11'h040, lat);
        chk("a_lat", lat, 6);
        chk("a_err", err, NoError);
        chk("a_popcnt", popcnt, 64);
        chk("a_rdata", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("a_ncmd", log_cmd.size(), 2);
        chk("a_cmd0", log_cmd[0], Zeroize);
        chk("a_cmd1", log_cmd[1], Read);
        chk("a_addr0", log_addr[0], 10'h020);
        chk("a_addr1", log_addr[1], 10'h020);
        ack_gap();

        // Two marginal rounds, then pass.
        log_cmd.delete();
        push(NoError, 0); push(NoError, 64'h000F_FFFF_FFFF_FFFF);
        push(NoError, 0); push(NoError, 64'h000F_FFFF_FFFF_FFFF);
        push(NoError, 0); push(NoError, 64'hFFFF_FFFF_FFFF_FFFF);
        run_req(11'h080, lat);
        chk("b_lat", lat, 16);
        chk("b_err", err, NoError);
        chk("b_ncmd", log_cmd.size(), 6);
        chk("b_cmd4", log_cmd[4], Zeroize);
        ack_gap();

        // Marginal on every round: retries exhausted.
        log_cmd.delete();
        repeat (3) begin push(NoError, 0); push(NoError, 64'h0003_FFFF_FFFF_FFFF); end
        run_req(11'h088, lat);
        chk("c_lat", lat, 16);
        chk("c_err", err, CheckFailError);
        chk("c_popcnt", popcnt, 50);
        chk("c_fsm_err", fsm_err, 0);
        ack_gap();

        // Misaligned address: immediate AccessError.
        log_cmd.delete();
        run_req(11'h044, lat);
        chk("mis_lat", lat, 1);
        chk("mis_err", err, AccessError);
        chk("mis_ncmd", log_cmd.size(), 0);
        ack_gap();

        // Correctable ECC on readback still counts as data.
        push(NoError, 0); push(MacroEccCorrError, 64'hFFFF_FFFF_FFFF_FFFF);
        run_req(11'h010, lat);
        chk("ecc_lat", lat, 6);
        chk("ecc_err", err, NoError);
        ack_gap();

        // Zeroize fails at the macro: no Read follows.
        log_cmd.delete();
        push(MacroError, 0);
        run_req(11'h018, lat);
        chk("me_lat", lat, 3);
        chk("me_err", err, MacroError);
        chk("me_ncmd", log_cmd.size(), 1);
        ack_gap();

        // Reset while waiting on the read response.
        push(NoError, 0); push(NoError, 64'hFFFF_FFFF_FFFF_FFFF);
        zaddr = 11'h060;
        req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        req = 1'b0;
        chk("mid_busy_rst", busy, 0);
        chk("mid_ack_rst", ack, 0);
        chk("mid_err_rst", err, NoError);
        chk("mid_rdata_rst", rdata, 0);
        chk("mid_addr_rst", otp_addr, 0);
        chk("mid_size_rst", otp_size, 3);
        do_reset();
        chk("mid_ack_after", ack, 0);
        chk("mid_busy_after", busy, 0);

        // Fatal readback: terminal error state.
        push(NoError, 0); push(NoError, 64'h0000_00FF_FFFF_FFFF);
        run_req(11'h100, lat);
        chk("f_lat", lat, 6);
        chk("f_err", err, FsmStateError);
        chk("f_fsm_err", fsm_err, 1);
        chk("f_popcnt", popcnt, 40);
        ack_gap();
        log_cmd.delete();
        run_req(11'h000, lat);
        chk("f2_lat", lat, 1);
        chk("f2_err", err, FsmStateError);
        chk("f2_ncmd", log_cmd.size(), 0);
        chk("f2_busy", busy, 0);
        ack_gap();
        do_reset();
        chk("f_fsm_err_rst", fsm_err, 0);

        // Stalled command, then escalation.
        log_cmd.delete();
        otp_ready = 1'b0;
        zaddr = 11'h080;
        req = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!(otp_valid && otp_cmd == Zeroize && otp_addr == 10'h040 && !ack)) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        esc = On;
        @(posedge clk); #1;
        chk("esc_valid", otp_valid, 0);
        chk("esc_fsm_err", fsm_err, 1);
        chk("esc_ack", ack, 1);
        chk("esc_err", err, FsmStateError);
        chk("esc_ncmd", log_cmd.size(), 0);
        req = 1'b0;
        otp_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
